ins_fetch_unit: RTL and testbench

Instruction fetch stage between the processor control unit and the instruction RAM. The unit owns the program counter, drives the RAM read address, and absorbs the RAM's two-cycle registered-address read latency. It presents each fetched instruction to the core with a valid/ready handshake and supports start, stop and jump redirects.

---
 rtl/fetch_pkg.sv | 20 ++
 rtl/ins_fetch_unit_if.sv | 36 +++
 rtl/pc_reg.sv | 27 ++
 rtl/ins_fetch_unit.sv | 135 +++++++++++++
 tb/tb_ins_fetch_unit.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch stage: FSM state encoding and default END opcode.
// Latency: n/a (declarations only).
// Backpressure: n/a. HALT state exists only when INS_FETCH_HALT_EN is defined.
package fetch_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,   // waiting for start
      ST_ADDR  = 3'd1,   // PC presented on ram_addr, RAM registers it this cycle
      ST_DATA  = 3'd2,   // ram_data valid, captured into the output registers
      ST_VALID = 3'd3    // instruction held for the core
`ifdef INS_FETCH_HALT_EN
      ,
      ST_HALT  = 3'd4    // END opcode fetched, parked until stop or reset
`endif
   } fetch_state_t;

   // Instruction word that halts fetch when the halt feature is built in.
   localparam int unsigned END_OPCODE_DEFAULT = 0;

endpackage

// File: rtl/ins_fetch_unit_if.sv
// Bundle of control, RAM-read and core-handshake signals of the fetch stage.
// Latency: n/a (wiring only).
// Backpressure: ins_valid/ins_ready handshake toward the core; RAM side has none.
// Modports: master = fetch unit side, slave = control unit / RAM / core side.
interface ins_fetch_unit_if #(
   parameter int INS_WIDTH  = 8,
   parameter int ADDR_WIDTH = 8
);
   // control unit -> fetch
   logic                  start;
   logic [ADDR_WIDTH-1:0] start_addr;
   logic                  stop;
   logic                  jump_en;
   logic [ADDR_WIDTH-1:0] jump_addr;
   // fetch <-> instruction RAM
   logic [ADDR_WIDTH-1:0] ram_addr;
   logic [INS_WIDTH-1:0]  ram_data;
   // fetch <-> core
   logic [INS_WIDTH-1:0]  ins_out;
   logic [ADDR_WIDTH-1:0] pc_out;
   logic                  ins_valid;
   logic                  ins_ready;
   logic                  busy;
   logic                  halted;

   modport master (
      input  start, start_addr, stop, jump_en, jump_addr, ram_data, ins_ready,
      output ram_addr, ins_out, pc_out, ins_valid, busy, halted
   );

   modport slave (
      output start, start_addr, stop, jump_en, jump_addr, ram_data, ins_ready,
      input  ram_addr, ins_out, pc_out, ins_valid, busy, halted
   );

endinterface

// File: rtl/pc_reg.sv
// Program counter register: load from an external address or increment with wrap.
// Latency: 1 cycle from load/inc to pc.
// Backpressure: none; load takes priority over inc.
// Ports: clk, rstN, load, load_addr, inc, pc (registered, resets to 0).
module pc_reg #(
   parameter int ADDR_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rstN,
   input  logic                  load,
   input  logic [ADDR_WIDTH-1:0] load_addr,
   input  logic                  inc,
   output logic [ADDR_WIDTH-1:0] pc
);

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         pc <= '0;
      end else if (load) begin
         pc <= load_addr;
      end else if (inc) begin
         // Natural overflow of the ADDR_WIDTH-bit add gives the modulo wrap.
         pc <= pc + ADDR_WIDTH'(1);
      end
   end

endmodule

// File: rtl/ins_fetch_unit.sv
// Instruction fetch stage: owns the PC, reads a 2-cycle instruction RAM, presents words to the core.
// Latency: start -> ins_valid in 3 cycles; one instruction per 3 cycles with ins_ready held high.
// Backpressure: VALID holds ins_out/pc_out/ins_valid while ins_ready is low; stop/jump discard.
// Ports: clk, rstN (async active-low), bus (ins_fetch_unit_if.master).
// Optional halt on END_OPCODE is built in when INS_FETCH_HALT_EN is defined.
module ins_fetch_unit
   import fetch_pkg::*;
#(
   parameter int                   INS_WIDTH  = 8,
   parameter int                   ADDR_WIDTH = 8,
   parameter logic [INS_WIDTH-1:0] END_OPCODE = INS_WIDTH'(END_OPCODE_DEFAULT)
) (
   input  logic                clk,
   input  logic                rstN,
   ins_fetch_unit_if.master    bus
);

   fetch_state_t          state;
   fetch_state_t          state_nxt;

   logic [ADDR_WIDTH-1:0] pc;
   logic                  pc_load;
   logic [ADDR_WIDTH-1:0] pc_load_addr;
   logic                  pc_inc;
   logic                  capture;

   logic [INS_WIDTH-1:0]  ins_q;
   logic [ADDR_WIDTH-1:0] pc_q;

   pc_reg #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_pc_reg (
      .clk       (clk),
      .rstN      (rstN),
      .load      (pc_load),
      .load_addr (pc_load_addr),
      .inc       (pc_inc),
      .pc        (pc)
   );

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      pc_load      = 1'b0;
      pc_load_addr = bus.start_addr;
      pc_inc       = 1'b0;
      capture      = 1'b0;

      if (bus.stop) begin
         // PC is kept so a later start can be compared against where fetch stopped.
         state_nxt = ST_IDLE;
      end else if (bus.jump_en &&
                   ((state == ST_ADDR) || (state == ST_DATA) || (state == ST_VALID))) begin
         // The in-flight or held word is dropped: no capture, no accept.
         pc_load      = 1'b1;
         pc_load_addr = bus.jump_addr;
         state_nxt    = ST_ADDR;
      end else begin
         case (state)
            ST_IDLE: begin
               if (bus.start) begin
                  pc_load      = 1'b1;
                  pc_load_addr = bus.start_addr;
                  state_nxt    = ST_ADDR;
               end
            end
            ST_ADDR: begin
               state_nxt = ST_DATA;
            end
            ST_DATA: begin
               // The END word is captured too, so the core can see what stopped fetch.
               capture = 1'b1;
`ifdef INS_FETCH_HALT_EN
               if (bus.ram_data == END_OPCODE) begin
                  state_nxt = ST_HALT;
               end else begin
                  state_nxt = ST_VALID;
               end
`else
               state_nxt = ST_VALID;
`endif
            end
            ST_VALID: begin
               if (bus.ins_ready) begin
                  pc_inc    = 1'b1;
                  state_nxt = ST_ADDR;
               end
            end
`ifdef INS_FETCH_HALT_EN
            ST_HALT: begin
               state_nxt = ST_HALT;
            end
`endif
            default: begin
               state_nxt = ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         ins_q <= '0;
         pc_q  <= '0;
      end else if (capture) begin
         ins_q <= bus.ram_data;
         pc_q  <= pc;
      end
   end

   // ram_addr comes straight from the PC register: no input-to-address path.
   assign bus.ram_addr  = pc;
   assign bus.ins_out   = ins_q;
   assign bus.pc_out    = pc_q;
   assign bus.ins_valid = (state == ST_VALID);

`ifdef INS_FETCH_HALT_EN
   assign bus.busy   = (state != ST_IDLE) && (state != ST_HALT);
   assign bus.halted = (state == ST_HALT);
`else
   // END_OPCODE has no effect in this build; fold it into a deliberately unused net.
   logic unused_end_opcode;
   assign unused_end_opcode = ^END_OPCODE;
   assign bus.busy   = (state != ST_IDLE);
   assign bus.halted = 1'b0;
`endif

endmodule

// File: tb/tb_ins_fetch_unit.sv
// Directed bench for ins_fetch_unit with a 2-cycle registered-address instruction RAM model.
// Expected words are queued when stimulus is driven and popped when ins_valid is seen.
// Outputs are sampled on the falling edge; inputs are driven on the falling edge.
module tb_ins_fetch_unit;
   import fetch_pkg::*;

   localparam int IW = 8;
   localparam int AW = 8;
   localparam logic [IW-1:0] END_OP = IW'(END_OPCODE_DEFAULT);

   typedef struct packed {
      logic [IW-1:0] ins;
      logic [AW-1:0] pc;
   } exp_t;

   logic clk  = 1'b0;
   logic rstN = 1'b0;
   int   vectors     = 0;
   int   miscompares = 0;

   exp_t          sb[$];
   logic [IW-1:0] mem [256];
   logic [AW-1:0] ram_addr_q;

   ins_fetch_unit_if #(.INS_WIDTH(IW), .ADDR_WIDTH(AW)) bus ();

   ins_fetch_unit #(
      .INS_WIDTH  (IW),
      .ADDR_WIDTH (AW),
      .END_OPCODE (END_OP)
   ) dut (
      .clk  (clk),
      .rstN (rstN),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   // Instruction RAM: address registered on the rising edge, data read from the registered address.
   always @(posedge clk) ram_addr_q <= bus.ram_addr;
   assign bus.ram_data = mem[ram_addr_q];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic push_exp(input logic [IW-1:0] ins, input logic [AW-1:0] pc);
      exp_t e;
      e.ins = ins;
      e.pc  = pc;
      sb.push_back(e);
   endtask

   // Waits (bounded) for ins_valid, checks the cycle count, then pops and compares the scoreboard.
   task automatic expect_valid(input string tag, input int lat);
      int   n;
      exp_t e;
      n = 0;
      do begin
         step();
         n++;
      end while (!bus.ins_valid && n < 20);
      check({tag, " latency"}, n, lat);
      check({tag, " expected pending"}, (sb.size() != 0), 1);
      if (sb.size() != 0) begin
         e = sb.pop_front();
         check({tag, " ins_out"}, bus.ins_out, e.ins);
         check({tag, " pc_out"}, bus.pc_out, e.pc);
      end
   endtask

   initial begin
      logic [IW-1:0] seq [4];
      seq[0] = 8'h11; seq[1] = 8'h22; seq[2] = 8'h33; seq[3] = 8'h44;

      for (int i = 0; i < 256; i++) mem[i] = 8'hC3;
      for (int i = 0; i < 4; i++) mem[i] = seq[i];
      mem[8'h04] = 8'h55;
      mem[8'h05] = 8'hEE;     // word in flight when the jump hits
      mem[8'h80] = 8'h99;
      mem[8'hFF] = 8'hA5;
      mem[8'h10] = 8'h61;
      mem[8'h11] = 8'h62;
      mem[8'h12] = END_OP;
      mem[8'h20] = 8'h71;
      mem[8'h30] = 8'h7A;

      bus.start      = 1'b0;
      bus.start_addr = '0;
      bus.stop       = 1'b0;
      bus.jump_en    = 1'b0;
      bus.jump_addr  = '0;
      bus.ins_ready  = 1'b0;

      // Reset state
      rstN = 1'b0;
      step();
      step();
      check("rst ins_out", bus.ins_out, 0);
      check("rst pc_out", bus.pc_out, 0);
      check("rst ins_valid", bus.ins_valid, 0);
      check("rst busy", bus.busy, 0);
      check("rst halted", bus.halted, 0);
      check("rst ram_addr", bus.ram_addr, 0);
      rstN = 1'b1;
      step();
      check("idle busy", bus.busy, 0);

      // Sequential fetch with ins_ready high
      bus.ins_ready  = 1'b1;
      bus.start_addr = 8'h00;
      bus.start      = 1'b1;
      for (int i = 0; i < 4; i++) push_exp(seq[i], AW'(i));
      step();
      bus.start = 1'b0;
      check("seq addr busy", bus.busy, 1);
      check("seq addr ram_addr", bus.ram_addr, 8'h00);
      expect_valid("seq0", 2);
      expect_valid("seq1", 3);
      expect_valid("seq2", 3);

      // Backpressure on the fourth word
      step();
      bus.ins_ready = 1'b0;
      expect_valid("seq3", 2);
      for (int i = 0; i < 5; i++) begin
         step();
         check("bp ins_valid", bus.ins_valid, 1);
         check("bp ins_out", bus.ins_out, 8'h44);
         check("bp pc_out", bus.pc_out, 8'h03);
      end
      bus.ins_ready = 1'b1;
      push_exp(8'h55, 8'h04);
      step();
      check("bp accept ins_valid", bus.ins_valid, 0);
      check("bp accept ram_addr", bus.ram_addr, 8'h04);
      expect_valid("bp next", 2);

      // Jump while the word at 0x05 is in DATA
      step();
      check("pre jump ram_addr", bus.ram_addr, 8'h05);
      step();
      bus.jump_en   = 1'b1;
      bus.jump_addr = 8'h80;
      push_exp(8'h99, 8'h80);
      step();
      bus.jump_en = 1'b0;
      check("jump ram_addr", bus.ram_addr, 8'h80);
      check("jump ins_valid", bus.ins_valid, 0);
      expect_valid("jump", 2);
      bus.ins_ready = 1'b0;

      // Stop from VALID
      bus.stop = 1'b1;
      step();
      bus.stop = 1'b0;
      check("stop ins_valid", bus.ins_valid, 0);
      check("stop busy", bus.busy, 0);
      check("stop keeps pc", bus.ram_addr, 8'h80);
      step();
      step();
      check("stopped ins_valid", bus.ins_valid, 0);

      // Wrap-around 0xFF -> 0x00
      bus.ins_ready  = 1'b1;
      bus.start_addr = 8'hFF;
      bus.start      = 1'b1;
      push_exp(8'hA5, 8'hFF);
      push_exp(8'h11, 8'h00);
      step();
      bus.start = 1'b0;
      expect_valid("wrap ff", 2);
      expect_valid("wrap 00", 3);
      bus.ins_ready = 1'b0;
      bus.stop      = 1'b1;
      step();
      bus.stop = 1'b0;

      // END opcode at 0x12
      bus.ins_ready  = 1'b1;
      bus.start_addr = 8'h10;
      bus.start      = 1'b1;
      push_exp(8'h61, 8'h10);
      push_exp(8'h62, 8'h11);
`ifndef INS_FETCH_HALT_EN
      push_exp(END_OP, 8'h12);
`endif
      step();
      bus.start = 1'b0;
      expect_valid("end w0", 2);
      expect_valid("end w1", 3);
`ifdef INS_FETCH_HALT_EN
      step();
      step();
      step();
      check("halt halted", bus.halted, 1);
      check("halt busy", bus.busy, 0);
      check("halt ins_valid", bus.ins_valid, 0);
      check("halt pc", bus.ram_addr, 8'h12);
      check("halt ins_out", bus.ins_out, END_OP);
      check("halt pc_out", bus.pc_out, 8'h12);
      step();
      check("halt sticky", bus.halted, 1);
      bus.stop = 1'b1;
      step();
      bus.stop = 1'b0;
      check("halt stop halted", bus.halted, 0);
      check("halt stop busy", bus.busy, 0);
      check("halt stop ins_valid", bus.ins_valid, 0);
`else
      expect_valid("end ordinary", 3);
      check("end halted", bus.halted, 0);
      bus.ins_ready = 1'b0;
      bus.stop      = 1'b1;
      step();
      bus.stop = 1'b0;
      check("end stop busy", bus.busy, 0);
`endif

      // Reset mid-fetch while in VALID
      bus.ins_ready  = 1'b0;
      bus.start_addr = 8'h20;
      bus.start      = 1'b1;
      push_exp(8'h71, 8'h20);
      step();
      bus.start = 1'b0;
      expect_valid("pre rst", 2);
      #2 rstN = 1'b0;
      #1;
      check("async rst ins_valid", bus.ins_valid, 0);
      check("async rst ins_out", bus.ins_out, 0);
      check("async rst pc_out", bus.pc_out, 0);
      check("async rst ram_addr", bus.ram_addr, 0);
      check("async rst busy", bus.busy, 0);
      check("async rst halted", bus.halted, 0);
      step();
      rstN = 1'b1;
      step();
      step();
      check("post rst ins_valid", bus.ins_valid, 0);
      check("post rst busy", bus.busy, 0);
      bus.start_addr = 8'h30;
      bus.start      = 1'b1;
      push_exp(8'h7A, 8'h30);
      step();
      bus.start = 1'b0;
      expect_valid("restart", 2);
      check("scoreboard drained", sb.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

endmodule
